// File: rtl/retire_trace_buffer_if.sv
// Retirement capture bus and AXI-Stream style trace output of the retire trace buffer.
// The master side produces retirements and sinks records; the slave side is the buffer.
interface retire_trace_buffer_if;
  logic         retire_valid;
  logic [31:0]  retire_pc;
  logic [31:0]  retire_instr;
  logic [4:0]   retire_rd;
  logic         retire_rd_we;
  logic [31:0]  retire_data;
  logic         trace_tvalid;
  logic         trace_tready;
  logic [134:0] trace_tdata;

  modport master (
    output retire_valid, retire_pc, retire_instr, retire_rd, retire_rd_we, retire_data,
    output trace_tready,
    input  trace_tvalid, trace_tdata
  );

  modport slave (
    input  retire_valid, retire_pc, retire_instr, retire_rd, retire_rd_we, retire_data,
    input  trace_tready,
    output trace_tvalid, trace_tdata
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// Never-stalling retirement trace FIFO: stamps each retired instruction with a cycle count,
// drops and counts records that do not fit, and marks the next stored record after a drop.
module retire_trace_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trace_enable,
  input  logic                    trace_flush,
  retire_trace_buffer_if.slave    bus,
  output logic [$clog2(DEPTH):0]  trace_level,
  output logic [DROP_CNT_W-1:0]   drop_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic        gap;
    logic [31:0] cycle;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } rec_t;

  rec_t                  mem_q [DEPTH];
  rec_t                  wr_rec;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  gap_q, gap_d;
  logic [31:0]           cycle_q;
  wire  [31:0]           cycle_d;
  logic                  tvalid, full, push_req, pop, accept, wr_en, drop;

  assign cycle_d  = cycle_q + 32'd1;
  assign tvalid   = (level_q != '0);
  assign full     = (level_q == LW'(DEPTH));
  assign push_req = bus.retire_valid & trace_enable;
  assign pop      = tvalid & bus.trace_tready;
  // A full buffer still takes the record when the head leaves in the same cycle.
  assign accept   = push_req & (~full | pop);
  assign wr_en    = accept & ~trace_flush;
  assign drop     = push_req & ~accept & ~trace_flush;

  assign wr_rec = '{gap:   gap_q,
                    cycle: cycle_q,
                    pc:    bus.retire_pc,
                    instr: bus.retire_instr,
                    rd:    bus.retire_rd,
                    we:    bus.retire_rd_we,
                    data:  bus.retire_data};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    gap_d    = gap_q;
    if (trace_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
      gap_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (wr_en) begin
        gap_d = 1'b0;
      end else if (drop) begin
        gap_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      gap_q    <= 1'b0;
      cycle_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      gap_q    <= gap_d;
      cycle_q  <= cycle_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity and tdata is gated.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_rec;
  end

  assign bus.trace_tvalid = tvalid;
  assign bus.trace_tdata  = tvalid ? mem_q[rd_ptr_q] : '0;
  assign trace_level      = level_q;
  assign drop_count       = drop_q;
endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Captures one record per retired instruction at the writeback boundary: cycle stamp, PC, raw instruction, rd, write enable and write data.
- Buffers records in a FIFO and presents them on an AXI-Stream-style output. The pipeline logger and debug/trace sinks drain that output at their own pace.
- Retirement never stalls. Records that do not fit are dropped and counted.
- A gap marker on the next stored record shows the sink where the trace is discontinuous.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- trace_enable  in  1  capture enable
- trace_flush  in  1  single-cycle flush request
- retire_valid  in  1  an instruction retires this cycle
- retire_pc  in  32  PC of the retiring instruction
- retire_instr  in  32  raw instruction word
- retire_rd  in  5  destination register
- retire_rd_we  in  1  register write enable
- retire_data  in  32  register write data
- trace_tvalid  out  1  record available
- trace_tready  in  1  sink accepts the record
- trace_tdata  out  135  record: [134] gap, [133:102] cycle, [101:70] pc, [69:38] instr, [37:33] rd, [32] we, [31:0] data
- trace_level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- drop_count  out  DROP_CNT_W  records dropped since the last reset or flush; saturating

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO empties; trace_tvalid=0, trace_tdata=0, trace_level=0, drop_count=0.
  - Pending-gap flag and cycle counter clear to 0.
- Cycle counter:
  - 32 bits; reads 0 in the first cycle after reset deasserts; +1 every cycle; wraps 0xFFFFFFFF -> 0.
  - Not affected by trace_flush.
- Definitions: push_req = retire_valid & trace_enable; pop = trace_tvalid & trace_tready.
- Capture:
  - A record is stamped with the counter value of the push_req cycle.
  - Fields are copied verbatim, including rd=0 with we=1.
  - The record is written at that clk edge.
- Accept rule: push_req is accepted if trace_level < DEPTH, or if pop happens in the same cycle (full with simultaneous pop -> level stays DEPTH).
- Drop:
  - push_req not accepted -> record discarded.
  - drop_count increments and saturates at 2^DROP_CNT_W-1.
  - Pending-gap flag sets.
- Gap marking:
  - The next accepted record is stored with gap=1 and the pending flag clears in the same edge.
  - All other records carry gap=0.
- Output:
  - First-word fall-through: trace_tvalid = (level != 0).
  - trace_tdata shows the oldest entry, valid in the same cycle the entry is written plus one (latency: capture at edge N, visible after edge N).
  - While trace_tvalid=1 and trace_tready=0, trace_tdata holds stable.
  - trace_tready is ignored while empty.
- Level:
  - +1 on accepted push without pop, -1 on pop without push, unchanged on both or neither.
  - Pointers wrap modulo DEPTH.
- Flush:
  - Has priority over push and pop in the same cycle.
  - On that edge: FIFO empties, level=0, drop_count=0, pending gap cleared.
  - A push_req in the flush cycle is discarded and not counted as a drop.
- trace_enable=0: retirements are ignored; no drop count, no gap. Draining continues.
- Reset mid-operation overrides everything, including flush; contents are lost.
- No combinational path from retire_* to trace_tvalid/trace_tdata. trace_tready affects only next-state logic.

Test Plan:
- Single record: reset, DEPTH=4, tready=1; retire in cycle 5 with pc=0x100, instr=0x00500093, rd=1, we=1, data=5 -> after the next edge tvalid=1, tdata={gap0, cycle5, 0x100, 0x00500093, 1, 1, 5}; popped next edge, level 0.
- Overflow and gap: DEPTH=4, tready=0, 6 consecutive retires with pc=0x0,4,8,C,10,14 -> level=4, drop_count=2; tready=1 drains pcs 0,4,8,C all with gap=0; the next retire, pc=0x18, arrives with gap=1, and the one after with gap=0.
- Full plus simultaneous pop: level=4, tready=1, retire pc=0x40 in the same cycle -> accepted, level stays 4, drop_count unchanged, pc=0x40 emerges fourth.
- Backpressure stability: 3 records stored, tready held 0 for 10 cycles -> tdata constant and equal to the first record; tready pulse of 1 cycle -> advances exactly one record.
- Flush priority: level=3, drop_count=5, flush asserted together with retire and tready=1 -> next cycle level=0, tvalid=0, drop_count=0, no record from the flush cycle ever appears; cycle counter continues.
- Enable and wrap:
  - trace_enable=0 with 8 retires -> level 0, drop_count 0.
  - Force the cycle counter to 0xFFFFFFFF, retire for two cycles -> stamps 0xFFFFFFFF then 0x00000000.
  - Drop-count saturation with DROP_CNT_W=2 -> holds at 3.
